memory_access: RTL and testbench

Pipeline MEM stage sitting directly downstream of `execute`. It consumes the ALU result, forwarded store data and destination register, and performs RV32I loads and stores over a req/ack data-memory port with arbitrary wait states. It returns aligned and extended load data, or the pass-through ALU result, to write-back. It stalls upstream while a memory transaction is outstanding.

---
 rtl/memory_access.sv | 172 +++++++++++++++++
 tb/tb_memory_access.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// rtl/memory_access.sv - RV32I MEM stage: aligned loads/stores over a req/ack data port with wait states
// Optional misalignment trap build: define MEM_MISALIGN_TRAP_EN.
module memory_access #(
    parameter int OPERAND_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [OPERAND_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0]    i_rf_data2,
    input  logic [4:0]               i_rd,
    input  logic                     i_mem_read,
    input  logic                     i_mem_write,
    input  logic [2:0]               i_funct3,
    output logic                     o_stall,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [OPERAND_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    output logic [3:0]               dmem_be,
    input  logic                     dmem_ack,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_result,
    output logic [4:0]               o_rd,
    output logic                     o_misaligned
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t state, next_state;

    logic                     accept;
    logic                     is_mem;
    logic                     is_store;
    logic                     size_b;
    logic                     size_h;
    logic                     trap;
    logic [3:0]               be_calc;
    logic [DATA_WIDTH-1:0]    wdata_calc;

    logic [OPERAND_WIDTH-1:0] addr_q;
    logic [2:0]               funct3_q;
    logic [4:0]               rd_q;
    logic [7:0]               byte_lane;
    logic [15:0]              half_lane;
    logic [DATA_WIDTH-1:0]    load_data;

    // A store flag overrides a simultaneous load flag.
    assign is_mem   = i_mem_read | i_mem_write;
    assign is_store = i_mem_write;
    assign size_b   = ~i_funct3[1] & ~i_funct3[0];
    assign size_h   = ~i_funct3[1] &  i_funct3[0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem && (i_funct3[1] ? (i_alu_result[1:0] != 2'b00)
                                         : (i_funct3[0] & i_alu_result[0]));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = i_rf_data2;
        if (size_b) begin
            be_calc    = 4'b0001 << i_alu_result[1:0];
            wdata_calc = {4{i_rf_data2[7:0]}};
        end else if (size_h) begin
            be_calc    = 4'b0011 << {i_alu_result[1], 1'b0};
            wdata_calc = {2{i_rf_data2[15:0]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_stall    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept = i_valid;
                if (i_valid && is_mem && !trap) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                o_stall = 1'b1;
                if (dmem_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        byte_lane = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_lane = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_data = {24'h0, byte_lane};
            3'b101:  load_data = {16'h0, half_lane};
            default: load_data = dmem_rdata;
        endcase
    end

    // dmem_* are only rewritten on accept, so they stay stable for the whole request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_rd       <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            addr_q     <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
        end else begin
            o_valid <= 1'b0;
            if (accept) begin
                if (!is_mem || trap) begin
                    o_valid  <= 1'b1;
                    o_result <= i_alu_result;
                    o_rd     <= i_rd;
                end else begin
                    addr_q     <= i_alu_result;
                    funct3_q   <= i_funct3;
                    rd_q       <= i_rd;
                    dmem_req   <= 1'b1;
                    dmem_we    <= is_store;
                    dmem_addr  <= {i_alu_result[OPERAND_WIDTH-1:2], 2'b00};
                    dmem_wdata <= wdata_calc;
                    dmem_be    <= be_calc;
                end
            end else if (state == REQ && dmem_ack) begin
                dmem_req <= 1'b0;
                o_valid  <= 1'b1;
                o_result <= dmem_we ? addr_q : load_data;
                o_rd     <= rd_q;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else if (accept) begin
            misaligned_q <= trap;
        end
    end

    assign o_misaligned = misaligned_q;
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_alu_result;
    logic [31:0] i_rf_data2;
    logic [4:0]  i_rd;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic        o_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd;
    logic        o_misaligned;

    int vectors = 0;
    int miscompares = 0;

    memory_access dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_alu_result (i_alu_result),
        .i_rf_data2   (i_rf_data2),
        .i_rd         (i_rd),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_funct3     (i_funct3),
        .o_stall      (o_stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .o_valid      (o_valid),
        .o_result     (o_result),
        .o_rd         (o_rd),
        .o_misaligned (o_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] data,
                         input logic [4:0] rd, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3);
        i_valid      = v;
        i_alu_result = alu;
        i_rf_data2   = data;
        i_rd         = rd;
        i_mem_read   = rd_en;
        i_mem_write  = wr_en;
        i_funct3     = f3;
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        tick;
        tick;
        check("rst_o_valid", {31'h0, o_valid}, 32'h0);
        check("rst_o_result", o_result, 32'h0);
        check("rst_o_rd", {27'h0, o_rd}, 32'h0);
        check("rst_o_misaligned", {31'h0, o_misaligned}, 32'h0);
        check("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        check("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
        check("rst_dmem_addr", dmem_addr, 32'h0);
        check("rst_dmem_wdata", dmem_wdata, 32'h0);
        check("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
        check("rst_o_stall", {31'h0, o_stall}, 32'h0);
        rst = 1'b0;
        tick;

        // Non-memory ops, back to back
        drive(1'b1, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 3'b010);
        check("alu_stall_pre", {31'h0, o_stall}, 32'h0);
        tick;
        check("alu_valid", {31'h0, o_valid}, 32'h1);
        check("alu_result", o_result, 32'h1234);
        check("alu_rd", {27'h0, o_rd}, 32'd5);
        check("alu_stall", {31'h0, o_stall}, 32'h0);
        drive(1'b1, 32'h55, 32'h0, 5'd6, 1'b0, 1'b0, 3'b000);
        tick;
        check("alu2_valid", {31'h0, o_valid}, 32'h1);
        check("alu2_result", o_result, 32'h55);
        check("alu2_rd", {27'h0, o_rd}, 32'd6);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        check("idle_valid_low", {31'h0, o_valid}, 32'h0);
        check("idle_result_hold", o_result, 32'h55);
        check("idle_ack_ignored_req", {31'h0, dmem_req}, 32'h0);
        tick;
        check("idle_ack_ignored_valid", {31'h0, o_valid}, 32'h0);

        // LB at 0x103, two wait cycles
        drive(1'b1, 32'h103, 32'h0, 5'd10, 1'b1, 1'b0, 3'b000);
        tick;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        check("lb_req", {31'h0, dmem_req}, 32'h1);
        check("lb_addr", dmem_addr, 32'h100);
        check("lb_be", {28'h0, dmem_be}, 32'b1000);
        check("lb_we", {31'h0, dmem_we}, 32'h0);
        check("lb_stall1", {31'h0, o_stall}, 32'h1);
        tick;
        check("lb_stall2", {31'h0, o_stall}, 32'h1);
        check("lb_req_w1", {31'h0, dmem_req}, 32'h1);
        check("lb_valid_w1", {31'h0, o_valid}, 32'h0);
        tick;
        check("lb_stall3", {31'h0, o_stall}, 32'h1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_0000;
        tick;
        dmem_ack   = 1'b0;
        check("lb_valid", {31'h0, o_valid}, 32'h1);
        check("lb_result", o_result, 32'hFFFF_FF80);
        check("lb_rd", {27'h0, o_rd}, 32'd10);
        check("lb_req_drop", {31'h0, dmem_req}, 32'h0);
        check("lb_stall_end", {31'h0, o_stall}, 32'h0);

        // LHU at 0x102, zero wait, then SB back to back
        drive(1'b1, 32'h102, 32'h0, 5'd7, 1'b1, 1'b0, 3'b101);
        tick;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        check("lhu_be", {28'h0, dmem_be}, 32'b1100);
        check("lhu_valid_early", {31'h0, o_valid}, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h8001_7F00;
        tick;
        dmem_ack   = 1'b0;
        check("lhu_valid", {31'h0, o_valid}, 32'h1);
        check("lhu_result", o_result, 32'h0000_8001);
        check("lhu_stall", {31'h0, o_stall}, 32'h0);

        // SB at 0x201 with load flag also set: store wins
        drive(1'b1, 32'h201, 32'hAABB_CCDD, 5'd9, 1'b1, 1'b1, 3'b000);
        tick;
        check("b2b_req", {31'h0, dmem_req}, 32'h1);
        check("sb_we", {31'h0, dmem_we}, 32'h1);
        check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
        check("sb_be", {28'h0, dmem_be}, 32'b0010);
        check("sb_addr", dmem_addr, 32'h200);
        tick;
        check("sb_hold_we", {31'h0, dmem_we}, 32'h1);
        check("sb_hold_wdata", dmem_wdata, 32'hDDDD_DDDD);
        check("sb_hold_be", {28'h0, dmem_be}, 32'b0010);
        check("sb_hold_addr", dmem_addr, 32'h200);
        check("sb_hold_req", {31'h0, dmem_req}, 32'h1);
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        check("sb_valid", {31'h0, o_valid}, 32'h1);
        check("sb_result", o_result, 32'h201);
        check("sb_rd", {27'h0, o_rd}, 32'd9);
        tick;
        check("sb_hold_result", o_result, 32'h201);
        check("sb_valid_pulse", {31'h0, o_valid}, 32'h0);

        // SH at 0x302 and LH at 0x100 (sign extension)
        drive(1'b1, 32'h302, 32'h1111_BEEF, 5'd3, 1'b0, 1'b1, 3'b001);
        tick;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check("sh_be", {28'h0, dmem_be}, 32'b1100);
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        drive(1'b1, 32'h100, 32'h0, 5'd4, 1'b1, 1'b0, 3'b001);
        tick;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        check("lh_be", {28'h0, dmem_be}, 32'b0011);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_8765;
        tick;
        dmem_ack   = 1'b0;
        check("lh_result", o_result, 32'hFFFF_8765);

        // Undefined funct3 011 behaves as LW
        drive(1'b1, 32'h104, 32'h0, 5'd8, 1'b1, 1'b0, 3'b011);
        tick;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        check("f3_011_be", {28'h0, dmem_be}, 32'b1111);
        check("f3_011_addr", dmem_addr, 32'h104);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_BABE;
        tick;
        dmem_ack   = 1'b0;
        check("f3_011_result", o_result, 32'hCAFE_BABE);

        // Reset in the middle of a request
        drive(1'b1, 32'h400, 32'h0, 5'd12, 1'b1, 1'b0, 3'b010);
        tick;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        check("mid_req_up", {31'h0, dmem_req}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", {31'h0, dmem_req}, 32'h0);
        check("mid_rst_stall", {31'h0, o_stall}, 32'h0);
        tick;
        rst = 1'b0;
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        check("mid_rst_no_valid", {31'h0, o_valid}, 32'h0);
        drive(1'b1, 32'hBEEF, 32'h0, 5'd13, 1'b0, 1'b0, 3'b000);
        tick;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
        check("post_rst_valid", {31'h0, o_valid}, 32'h1);
        check("post_rst_result", o_result, 32'hBEEF);

        // LW at misaligned 0x102
        drive(1'b1, 32'h102, 32'h0, 5'd14, 1'b1, 1'b0, 3'b010);
        tick;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_req", {31'h0, dmem_req}, 32'h0);
        check("mis_valid", {31'h0, o_valid}, 32'h1);
        check("mis_flag", {31'h0, o_misaligned}, 32'h1);
        check("mis_result", o_result, 32'h102);
        check("mis_stall", {31'h0, o_stall}, 32'h0);
`else
        check("mis_req", {31'h0, dmem_req}, 32'h1);
        check("mis_addr", dmem_addr, 32'h100);
        check("mis_be", {28'h0, dmem_be}, 32'b1111);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0102_0304;
        tick;
        dmem_ack   = 1'b0;
        check("mis_result", o_result, 32'h0102_0304);
        check("mis_flag", {31'h0, o_misaligned}, 32'h0);
`endif
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
